// File: rtl/slc3_sram_model.sv
// Word-addressed SLC-3 memory with a ROM-driven init sequence after reset.
// Core reads have a fixed one-cycle latency; core accesses are gated until init finishes.
`timescale 1ns/1ps
module slc3_sram_model #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned INIT_WORDS = 64
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [15:0]           ADDR,
   input  logic                  OE,
   input  logic                  WE,
   input  logic [15:0]           Data_to_SRAM,
   output logic [15:0]           Data_from_SRAM,
   output logic [DEPTH_LOG2-1:0] rom_addr,
   input  logic [15:0]           rom_data,
   output logic                  mem_ready
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;
   localparam logic [DEPTH_LOG2:0] INIT_LIMIT = (DEPTH_LOG2 + 1)'(INIT_WORDS);

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      FLUSH = 2'd1,
      READY = 2'd2
   } state_t;

   state_t                  state;
   logic [DEPTH_LOG2-1:0]   cnt;
   logic [DEPTH_LOG2-1:0]   stage_addr;
   logic                    stage_valid;
   logic [15:0]             mem [DEPTH];

   logic                    in_range;
   logic [DEPTH_LOG2-1:0]   index;
   logic [15:0]             stage_word;
   logic                    core_wr;
   logic                    core_rd;
   logic                    wr_en;
   logic [DEPTH_LOG2-1:0]   wr_idx;
   logic [15:0]             wr_data;

   // Anything above the implemented depth (e.g. the I/O page) is out of range.
   assign in_range   = (ADDR >> DEPTH_LOG2) == 16'h0000;
   assign index      = ADDR[DEPTH_LOG2-1:0];
   assign stage_word = ({1'b0, stage_addr} < INIT_LIMIT) ? rom_data : 16'h0000;
   assign core_wr    = (state == READY) && WE && in_range;
   assign core_rd    = (state == READY) && OE && !WE;
   assign rom_addr   = cnt;

   // Single write port: staged init writes and core writes are mutually exclusive by state.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = 16'h0000;
      if (stage_valid) begin
         wr_en   = 1'b1;
         wr_idx  = stage_addr;
         wr_data = stage_word;
      end else if (core_wr) begin
         wr_en   = 1'b1;
         wr_idx  = index;
         wr_data = Data_to_SRAM;
      end
   end

   // Storage itself is never reset; init overwrites every word anyway.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Sequencer: walk all addresses feeding the ROM, drain the last staged word, then serve the core.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state          <= INIT;
         cnt            <= '0;
         stage_addr     <= '0;
         stage_valid    <= 1'b0;
         mem_ready      <= 1'b0;
         Data_from_SRAM <= 16'h0000;
      end else begin
         case (state)
            INIT: begin
               stage_addr  <= cnt;
               stage_valid <= 1'b1;
               cnt         <= cnt + 1'b1;
               if (cnt == LAST_IDX) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               stage_valid <= 1'b0;
               state       <= READY;
               mem_ready   <= 1'b1;
            end
            READY: begin
               if (core_rd) begin
                  Data_from_SRAM <= in_range ? mem[index] : 16'h0000;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slc3_sram_model.sv
// Scoreboard bench for slc3_sram_model: reads push expected words, a monitor pops and compares.
`timescale 1ns/1ps
module tb_slc3_sram_model;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic        oe;
   logic        we;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [9:0]  rom_addr;
   logic [15:0] rom_data;
   logic        mem_ready;

   int          errors;
   int          checks;
   logic [15:0] exp_q[$];
   logic [15:0] last_exp;
   logic        rd_pend;

   slc3_sram_model #(.DEPTH_LOG2(10), .INIT_WORDS(64)) dut (
      .Clk(clk),
      .Reset(rst),
      .ADDR(addr),
      .OE(oe),
      .WE(we),
      .Data_to_SRAM(wdata),
      .Data_from_SRAM(rdata),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Init ROM model: registered, returns address xor 0x1234.
   always @(posedge clk) begin
      rom_data <= {6'd0, rom_addr} ^ 16'h1234;
   end

   // A read accepted on this edge produces its word on the DUT output after this edge.
   always @(posedge clk or posedge rst) begin
      if (rst) rd_pend <= 1'b0;
      else     rd_pend <= oe && !we && mem_ready;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected word for every completed read.
   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL read_unexpected: got %0h expected no read", rdata);
         end else begin
            check("read_data", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] a, input logic o, input logic w, input logic [15:0] d);
      addr  = a;
      oe    = o;
      we    = w;
      wdata = d;
   endtask

   task automatic idle();
      applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
      applyStimulus(a, 1'b1, 1'b0, 16'h0000);
      exp_q.push_back(exp);
      last_exp = exp;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      applyStimulus(a, 1'b0, 1'b1, d);
      @(posedge clk); #1;
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Counts edges after reset release until mem_ready; injects gated core accesses at cycle 10.
   task automatic run_init(input int abort_at, output int edges);
      edges = 0;
      while (edges < 2000) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 10) applyStimulus(16'h0200, 1'b1, 1'b1, 16'h5555);
         if (edges == 11) applyStimulus(16'h0005, 1'b1, 1'b0, 16'h0000);
         if (edges == 12) begin
            idle();
            check("init_read_gated", {16'd0, rdata}, 32'h0);
         end
         if (edges == abort_at) return;
         if (mem_ready) return;
      end
   endtask

   task automatic checkOutput();
      repeat (3) @(posedge clk);
      #1 check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic check_test1_values();
      do_read(16'h0005, 16'h1231);
      do_read(16'h0064, 16'h0000);
      do_read(16'h003F, 16'h120B);
      do_read(16'h0040, 16'h0000);
      do_read(16'h0200, 16'h0000);
   endtask

   initial begin
      int n;
      errors = 0;
      checks = 0;
      last_exp = 16'h0000;
      idle();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1 check("reset_ready", {31'd0, mem_ready}, 32'h0);
      check("reset_rdata", {16'd0, rdata}, 32'h0);
      check("reset_rom_addr", {22'd0, rom_addr}, 32'h0);

      do_reset();
      check("ready_low_after_release", {31'd0, mem_ready}, 32'h0);
      run_init(-1, n);
      check("init_edges", n, 1025);
      check_test1_values();

      // Write then immediate read of the same word.
      do_write(16'h0020, 16'hBEEF);
      do_read(16'h0020, 16'hBEEF);

      // Simultaneous OE and WE: write lands, output holds.
      do_read(16'h0010, 16'h1224);
      applyStimulus(16'h0010, 1'b1, 1'b1, 16'hAAAA);
      @(posedge clk); #1;
      idle();
      check("oe_we_hold", {16'd0, rdata}, {16'd0, last_exp});
      do_read(16'h0010, 16'hAAAA);

      // Out-of-range writes discarded, out-of-range reads return zero; top word boundary.
      do_write(16'hFFFF, 16'h1111);
      do_read(16'h03FF, 16'h0000);
      do_read(16'hFFFF, 16'h0000);
      do_read(16'h0400, 16'h0000);
      do_write(16'h03FF, 16'h7777);
      do_read(16'h03FF, 16'h7777);
      do_read(16'h0020, 16'hBEEF);
      checkOutput();

      // Asynchronous reset while serving: everything clears without a clock edge.
      #2 rst = 1'b1;
      #1 check("async_rst_ready", {31'd0, mem_ready}, 32'h0);
      check("async_rst_rdata", {16'd0, rdata}, 32'h0);
      do_reset();

      // Abort init at cycle 500.
      run_init(500, n);
      check("abort_rom_addr_before", {22'd0, rom_addr}, 32'd500);
      rst = 1'b1;
      #1 check("abort_ready", {31'd0, mem_ready}, 32'h0);
      check("abort_rom_addr", {22'd0, rom_addr}, 32'h0);
      check("abort_rdata", {16'd0, rdata}, 32'h0);
      do_reset();
      run_init(-1, n);
      check("reinit_edges", n, 1025);
      check_test1_values();
      do_read(16'h0020, 16'h1214);
      do_read(16'h0010, 16'h1224);
      do_read(16'h03FF, 16'h0000);
      checkOutput();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
